// File: rtl/ifu_if.sv
// Memory read channel between the IFU (master) and instruction memory (slave):
// request carries the word address, response returns the fetched word.
interface ifu_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: IDLE -> REQ -> WAIT -> HOLD loop with a WAIT timeout fault.
// Optional macro IFU_MISALIGN_CHECK_EN faults misaligned fetch addresses without a bus request.
module ifu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dnpc_i,
  output logic        pc_wen_o,
  ifu_if.master       mem,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_fault_o
);

  localparam logic [7:0] TMO = TIMEOUT_CYCLES[7:0];

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_q, pc_d;
  logic        fault_q, fault_d;
  logic        latch;
  logic [7:0]  cnt_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      inst_q  <= '0;
      pc_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      inst_q  <= inst_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    inst_d  = inst_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    latch   = 1'b0;
    cnt_nxt = cnt_q + 8'd1;

    case (state_q)
      S_IDLE: latch = 1'b1;
      S_REQ: begin
        cnt_d = '0;
        if (mem.req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_nxt;
        // a response landing on the timeout cycle still counts as good data
        if (mem.rsp_valid) begin
          state_d = S_HOLD;
          inst_d  = mem.rsp_data;
          pc_d    = addr_q;
          fault_d = 1'b0;
        end else if (cnt_nxt == TMO) begin
          state_d = S_HOLD;
          inst_d  = '0;
          pc_d    = addr_q;
          fault_d = 1'b1;
        end
      end
      S_HOLD: latch = inst_ready_i;
      default: state_d = S_IDLE;
    endcase

    if (latch) begin
      addr_d  = dnpc_i;
      state_d = S_REQ;
`ifdef IFU_MISALIGN_CHECK_EN
      if (dnpc_i[1:0] != 2'b00) begin
        state_d = S_HOLD;
        inst_d  = '0;
        pc_d    = dnpc_i;
        fault_d = 1'b1;
      end
`endif
    end
  end

  assign mem.req_valid = (state_q == S_REQ);
  assign mem.rsp_ready = (state_q == S_WAIT);
`ifdef IFU_MISALIGN_CHECK_EN
  assign mem.req_addr  = addr_q;
`else
  assign mem.req_addr  = {addr_q[31:2], 2'b00};
`endif

  assign inst_valid_o = (state_q == S_HOLD);
  assign pc_wen_o     = (state_q == S_HOLD) & inst_ready_i;
  assign inst_o       = inst_q;
  assign inst_pc_o    = pc_q;
  assign inst_fault_o = fault_q;

endmodule
